// File: rtl/filter_chain_pkg.sv
// Shared types and default tuning constants for the filter chain router.
package filter_chain_pkg;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_t;

  localparam int DEF_BPM_BASE  = 100;
  localparam int DEF_BPM_STEP  = 40;
  localparam int DEF_HYST      = 4;
  localparam int DEF_BEAT_HOLD = 2;

endpackage

// File: rtl/filter_chain_router_bpm_depth_mapper.sv
// Hysteretic mapping of a BPM estimate onto a filter depth (1..NUM_STAGES).
// A level above the current base must be cleared by +HYST to switch on; a
// level at or below the current base stays on until bpm drops below -HYST.
module bpm_depth_mapper
  import filter_chain_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int BPM_BASE   = DEF_BPM_BASE,
  parameter int BPM_STEP   = DEF_BPM_STEP,
  parameter int HYST       = DEF_HYST,
  parameter int DEPTH_W    = $clog2(NUM_STAGES + 1)
) (
  input  logic [15:0]        bpm,
  input  logic [DEPTH_W-1:0] cur_base,
  output logic [DEPTH_W-1:0] next_base
);

  logic [16:0] thr;
  logic        level_on;

  // highest level whose hysteresis-adjusted threshold is met wins
  always_comb begin
    next_base = DEPTH_W'(1);
    thr       = '0;
    level_on  = 1'b0;
    for (int k = 2; k <= NUM_STAGES; k++) begin
      thr = 17'(BPM_BASE) + 17'((k - 2) * BPM_STEP);
      if (k <= int'(cur_base))
        level_on = ({1'b0, bpm} + 17'(HYST)) >= thr;
      else
        level_on = {1'b0, bpm} >= (thr + 17'(HYST));
      if (level_on)
        next_base = DEPTH_W'(k);
    end
  end

endmodule

// File: rtl/filter_chain_router.sv
// Selects raw pixels or one tap of an external filter cascade per frame,
// with depth driven by a hysteretic BPM map plus a short post-beat boost.
//
// state    | meaning
// WAIT_SOF | after reset, discard everything until the first valid sop
// RUN      | frame-aligned routing; depth re-latched on each valid sop
module filter_chain_router
  import filter_chain_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_STAGES = 4,
  parameter int BPM_BASE   = DEF_BPM_BASE,
  parameter int BPM_STEP   = DEF_BPM_STEP,
  parameter int HYST       = DEF_HYST,
  parameter int BEAT_HOLD  = DEF_BEAT_HOLD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DATA_W-1:0]                  pixel_in,
  input  logic                               pixel_in_valid,
  input  logic                               pixel_in_sop,
  input  logic                               pixel_in_eop,
  input  logic [NUM_STAGES*DATA_W-1:0]       tap_data,
  input  logic [NUM_STAGES-1:0]              tap_valid,
  input  logic [15:0]                        bpm_estimate,
  input  logic                               beat_detected,
  input  logic                               filter_enable,
  output logic [DATA_W-1:0]                  pixel_out,
  output logic                               pixel_out_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0]    active_depth,
  output logic [15:0]                        frame_count
);

  localparam int DEPTH_W = $clog2(NUM_STAGES + 1);
  localparam int BOOST_W = (BEAT_HOLD < 1) ? 1 : $clog2(BEAT_HOLD + 1);

  state_t              state;
  logic [DEPTH_W-1:0]  base_depth;
  logic [DEPTH_W-1:0]  next_base;
  logic [DEPTH_W-1:0]  eff_depth;
  logic [DEPTH_W-1:0]  sel_depth;
  logic [BOOST_W-1:0]  boost_cnt;
  logic                sop_seen;
  logic                eop_seen;
  logic                in_run;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_valid;

  assign sop_seen = pixel_in_valid & pixel_in_sop;
  assign eop_seen = pixel_in_valid & pixel_in_eop;
  // the sop pixel itself is routed even when it is what leaves WAIT_SOF
  assign in_run   = (state == RUN) | sop_seen;

  bpm_depth_mapper #(
    .NUM_STAGES (NUM_STAGES),
    .BPM_BASE   (BPM_BASE),
    .BPM_STEP   (BPM_STEP),
    .HYST       (HYST),
    .DEPTH_W    (DEPTH_W)
  ) u_mapper (
    .bpm        (bpm_estimate),
    .cur_base   (base_depth),
    .next_base  (next_base)
  );

  // effective depth and source mux; on a sop cycle the new depth applies at once
  always_comb begin
    if (!filter_enable)
      eff_depth = '0;
    else if ((boost_cnt != '0) && (base_depth < DEPTH_W'(NUM_STAGES)))
      eff_depth = base_depth + DEPTH_W'(1);
    else
      eff_depth = base_depth;

    sel_depth = sop_seen ? eff_depth : active_depth;
    sel_data  = pixel_in;
    sel_valid = pixel_in_valid;
    if (sel_depth != '0) begin
      sel_data  = tap_data[(int'(sel_depth) - 1) * DATA_W +: DATA_W];
      sel_valid = tap_valid[int'(sel_depth) - 1];
    end
  end

  // state, depth tracking, boost timer, frame counter and registered output
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= WAIT_SOF;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      active_depth    <= '0;
      frame_count     <= '0;
      boost_cnt       <= '0;
      base_depth      <= DEPTH_W'(1);
    end else begin
      base_depth <= next_base;

      if (beat_detected)
        boost_cnt <= BOOST_W'(BEAT_HOLD);
      else if (eop_seen && (boost_cnt != '0))
        boost_cnt <= boost_cnt - BOOST_W'(1);

      if (sop_seen) begin
        state        <= RUN;
        active_depth <= eff_depth;
      end

      if (in_run) begin
        pixel_out_valid <= sel_valid;
        if (sel_valid)
          pixel_out <= sel_data;
        if (eop_seen)
          frame_count <= frame_count + 16'd1;
      end else begin
        pixel_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filter_chain_router.sv
// Directed bench: stimulus pushes hand-derived expected pixels, a negedge
// monitor pops them whenever the router presents a valid output.
module tb_filter_chain_router;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pixel_in;
  logic        pixel_in_valid;
  logic        pixel_in_sop;
  logic        pixel_in_eop;
  logic [31:0] tap_data;
  logic [3:0]  tap_valid;
  logic [15:0] bpm_estimate;
  logic        beat_detected;
  logic        filter_enable;
  logic [7:0]  pixel_out;
  logic        pixel_out_valid;
  logic [2:0]  active_depth;
  logic [15:0] frame_count;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  filter_chain_router #(
    .DATA_W(8), .NUM_STAGES(4), .BPM_BASE(100), .BPM_STEP(40), .HYST(4), .BEAT_HOLD(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .pixel_in_sop    (pixel_in_sop),
    .pixel_in_eop    (pixel_in_eop),
    .tap_data        (tap_data),
    .tap_valid       (tap_valid),
    .bpm_estimate    (bpm_estimate),
    .beat_detected   (beat_detected),
    .filter_enable   (filter_enable),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .active_depth    (active_depth),
    .frame_count     (frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (pixel_out_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %02h, expected no output", pixel_out);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("pixel_out", int'(pixel_out), int'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] pix, input logic v, input logic sop, input logic eop,
                       input logic [31:0] taps, input logic [3:0] tv, input logic beat);
    pixel_in       = pix;
    pixel_in_valid = v;
    pixel_in_sop   = sop;
    pixel_in_eop   = eop;
    tap_data       = taps;
    tap_valid      = tv;
    beat_detected  = beat;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
  endtask

  // pixel i: pixel_in = seed+i, tap k = k*16+i; dep is the hand-derived depth
  task automatic send_frame(input int n, input int dep, input logic [7:0] seed,
                            input bit beat_eop, input bit no_eop, input int fe_off_at);
    for (int i = 0; i < n; i++) begin
      logic [31:0] taps;
      logic [7:0]  pix;
      logic [7:0]  e;
      pix = seed + 8'(i);
      for (int k = 0; k < 4; k++) taps[k*8 +: 8] = 8'((k + 1) * 16 + i);
      e = (dep == 0) ? pix : taps[(dep - 1)*8 +: 8];
      if (i == fe_off_at) filter_enable = 1'b0;
      exp_q.push_back(e);
      drive(pix, 1'b1, i == 0, (i == n - 1) && !no_eop, taps, 4'hF, beat_eop && (i == n - 1));
    end
  endtask

  int bpm_t[4] = '{90, 150, 138, 135};
  int dep_t[4] = '{1, 3, 3, 2};

  initial begin
    reset = 1'b1; pixel_in = '0; pixel_in_valid = 0; pixel_in_sop = 0; pixel_in_eop = 0;
    tap_data = '0; tap_valid = '0; bpm_estimate = 16'd90; beat_detected = 0; filter_enable = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel_out", int'(pixel_out), 0);
    check("rst_valid", int'(pixel_out_valid), 0);
    check("rst_depth", int'(active_depth), 0);
    check("rst_frame_count", int'(frame_count), 0);
    reset = 1'b0;

    // valid pixels without sop are dropped, eop there does not count
    drive(8'h11, 1'b1, 1'b0, 1'b0, 32'h44332211, 4'hF, 1'b0);
    check("nosop_valid0", int'(pixel_out_valid), 0);
    drive(8'h22, 1'b1, 1'b0, 1'b1, 32'h44332211, 4'hF, 1'b0);
    check("nosop_valid1", int'(pixel_out_valid), 0);
    check("nosop_frame_count", int'(frame_count), 0);

    // depth 1 at bpm 90, tap 1 value appears one cycle later
    idle(2);
    exp_q.push_back(8'hA5);
    drive(8'h01, 1'b1, 1'b1, 1'b0, 32'h000000A5, 4'b0001, 1'b0);
    check("d1_depth", int'(active_depth), 1);
    check("d1_pixel_out", int'(pixel_out), 8'hA5);
    check("d1_valid", int'(pixel_out_valid), 1);
    exp_q.push_back(8'h5A);
    drive(8'h02, 1'b1, 1'b0, 1'b1, 32'h0000005A, 4'b0001, 1'b0);
    check("d1_frame_count", int'(frame_count), 1);

    // bpm ramp with hysteresis around 140
    for (int f = 0; f < 4; f++) begin
      bpm_estimate = 16'(bpm_t[f]);
      idle(2);
      send_frame(3, dep_t[f], 8'h80, 1'b0, 1'b0, -1);
      check("ramp_depth", int'(active_depth), dep_t[f]);
      check("ramp_frame_count", int'(frame_count), 2 + f);
    end

    // beat on eop boosts the next two frames
    bpm_estimate = 16'd90;
    idle(2);
    send_frame(2, 1, 8'h90, 1'b1, 1'b0, -1);
    check("beat_src_depth", int'(active_depth), 1);
    send_frame(2, 2, 8'h90, 1'b0, 1'b0, -1);
    check("boost_depth0", int'(active_depth), 2);
    send_frame(2, 2, 8'h90, 1'b0, 1'b0, -1);
    check("boost_depth1", int'(active_depth), 2);
    send_frame(2, 1, 8'h90, 1'b0, 1'b0, -1);
    check("boost_expired", int'(active_depth), 1);
    check("boost_frame_count", int'(frame_count), 9);

    // filter_enable drop mid-frame only takes effect at the next sop
    bpm_estimate = 16'd150;
    idle(2);
    send_frame(4, 3, 8'hA0, 1'b0, 1'b0, 2);
    check("fe_cur_depth", int'(active_depth), 3);
    idle(1);
    send_frame(3, 0, 8'h60, 1'b0, 1'b0, -1);
    check("fe_bypass_depth", int'(active_depth), 0);
    check("fe_frame_count", int'(frame_count), 11);
    filter_enable = 1'b1;

    // truncated frame: no count, next sop re-latches
    idle(2);
    send_frame(2, 3, 8'hB0, 1'b0, 1'b1, -1);
    check("trunc_depth", int'(active_depth), 3);
    check("trunc_frame_count", int'(frame_count), 11);
    bpm_estimate = 16'd90;
    idle(2);
    send_frame(2, 1, 8'hB8, 1'b0, 1'b0, -1);
    check("relatch_depth", int'(active_depth), 1);
    check("relatch_frame_count", int'(frame_count), 12);

    // single-pixel frame
    send_frame(1, 1, 8'hC0, 1'b0, 1'b0, -1);
    check("one_px_depth", int'(active_depth), 1);
    check("one_px_frame_count", int'(frame_count), 13);

    // boost at top depth saturates at NUM_STAGES
    bpm_estimate = 16'd200;
    idle(2);
    drive(8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1);
    send_frame(2, 4, 8'hD0, 1'b0, 1'b0, -1);
    check("sat_depth0", int'(active_depth), 4);
    send_frame(2, 4, 8'hD0, 1'b0, 1'b0, -1);
    check("sat_depth1", int'(active_depth), 4);

    // reset mid-frame at depth 2
    bpm_estimate = 16'd120;
    idle(2);
    send_frame(2, 2, 8'hE0, 1'b0, 1'b1, -1);
    check("pre_rst_depth", int'(active_depth), 2);
    reset = 1'b1;
    drive(8'hE2, 1'b1, 1'b0, 1'b0, 32'h42322212, 4'hF, 1'b0);
    check("mid_rst_valid", int'(pixel_out_valid), 0);
    check("mid_rst_pixel_out", int'(pixel_out), 0);
    check("mid_rst_depth", int'(active_depth), 0);
    check("mid_rst_frame_count", int'(frame_count), 0);
    reset = 1'b0;
    drive(8'hE3, 1'b1, 1'b0, 1'b0, 32'h43332313, 4'hF, 1'b0);
    drive(8'hE4, 1'b1, 1'b0, 1'b1, 32'h44342414, 4'hF, 1'b0);
    check("post_rst_valid", int'(pixel_out_valid), 0);
    check("post_rst_frame_count", int'(frame_count), 0);
    send_frame(2, 2, 8'hF0, 1'b0, 1'b0, -1);
    check("post_rst_depth", int'(active_depth), 2);
    check("post_rst_frame_count1", int'(frame_count), 1);

    idle(3);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
